aes_ahb_host: RTL and testbench
===============================

AES_AHB_HOST -- requirements
Module: aes_ahb_host

Parameters
REQ-001 SHALL provide BASE_ADDR, default 32'h0000_0000, byte base address of the AES register block.
REQ-002 SHALL provide POLL_LIMIT, default 1024, maximum STAT0 reads per operation before timeout.

Interface
REQ-003 SHALL have HCLK  in  1  clock; reset HRESETn, asynchronous, active-low; clock HCLK.
REQ-004 SHALL have HRESETn  in  1  asynchronous active-low reset.
REQ-005 SHALL have cmd_valid  in  1  encrypt request; cmd_ready  out  1  host idle and able to accept.
REQ-006 SHALL have cmd_key  in  128  key; cmd_pt  in  128  plaintext; both sampled on acceptance.
REQ-007 SHALL have rsp_valid  out  1  one-cycle completion pulse; rsp_err  out  1  error qualifier; rsp_ct  out  128  ciphertext.
REQ-008 SHALL have HADDR  out  32; HTRANS  out  2; HWRITE  out  1; HSIZE  out  3; HBURST  out  3; HWDATA  out  32 (AHB-Lite manager outputs).
REQ-009 SHALL have HRDATA  in  32; HREADY  in  1; HRESP  in  1 (AHB-Lite manager inputs).

Function
REQ-010 SHALL accept a command when cmd_valid && cmd_ready; cmd_ready SHALL be 1 only in IDLE.
REQ-011 SHALL drive HSIZE=3'b010 and HBURST=3'b000 constantly; every transfer is a single NONSEQ word transfer.
REQ-012 SHALL use FSM states IDLE, ADDR, DATA, DONE; a 4-bit step index selects the current transfer.
REQ-013 Step order SHALL be: writes KEY0..KEY3 (BASE+0x10..0x1C), PT0..PT3 (BASE+0x20..0x2C), CTRL0 (BASE+0x00, data 32'h1); STAT0 polls (BASE+0x08); reads CT0..CT3 (BASE+0x30..0x3C).
REQ-014 Word mapping SHALL be KEYn = cmd_key[32n+31:32n], PTn = cmd_pt[32n+31:32n], CTn -> rsp_ct[32n+31:32n].
REQ-015 In ADDR, SHALL drive HTRANS=2'b10 with HADDR/HWRITE of the current step; SHALL hold them unchanged until HREADY=1, then enter DATA.
REQ-016 In DATA, SHALL drive HTRANS=2'b00; for writes SHALL drive HWDATA for the step; SHALL stay until HREADY=1.
REQ-017 Outside data phases of writes, HWDATA SHALL be 0; in IDLE/DONE, HTRANS SHALL be 2'b00 and HADDR 0.
REQ-018 On DATA completion with HRESP=0: read steps SHALL capture HRDATA, then advance to the next step's ADDR the following cycle; zero-wait-state transfers take exactly 2 cycles.
REQ-019 Poll rule: STAT0 bit0=1 (done), or bit1=0 after any earlier poll in this operation returned bit1=1, SHALL end polling and advance to CT0; otherwise SHALL reissue STAT0.
REQ-020 A 16-bit poll counter SHALL count STAT0 reads; reaching POLL_LIMIT without completion SHALL go to DONE with rsp_err=1.
REQ-021 HRESP=1 in any data phase SHALL abort remaining steps and go to DONE with rsp_err=1; the error transfer is not retried.
REQ-022 DONE SHALL last one cycle asserting rsp_valid=1, then return to IDLE; rsp_ct and rsp_err SHALL hold until the next acceptance.
REQ-023 rsp_ct SHALL be all-zero whenever rsp_err=1.
REQ-024 cmd_key/cmd_pt changes after acceptance SHALL NOT affect the operation (internal copies).
REQ-025 Zero-wait-state, one-poll latency: rsp_valid SHALL assert 29 cycles after the acceptance edge (9 writes + 1 poll + 4 reads, 2 cycles each, plus DONE).

Reset
REQ-026 On HRESETn low, SHALL asynchronously force IDLE, step 0, poll counter 0, HTRANS=2'b00, HADDR=0, HWRITE=0, HWDATA=0, rsp_valid=0, rsp_err=0, rsp_ct=0, cmd_ready=1 after release.
REQ-027 Reset mid-operation SHALL abandon the operation without asserting rsp_valid.

Verification
REQ-028 Zero-wait subordinate; key 0x000102..0F, pt 0x00112233..EEFF; STAT0 returns done on first poll -> exact 14-transfer address/data sequence, rsp_valid at cycle 29, rsp_ct equals CT words returned.
REQ-029 HREADY low 3 cycles in KEY2 data phase -> HADDR/HTRANS/HWDATA stable, no step skipped, rsp_valid delayed 3 cycles.
REQ-030 STAT0 returns 0x2 four times then 0x0 -> exactly 5 polls, then CT0 read, rsp_err=0.
REQ-031 POLL_LIMIT=4, STAT0 always 0x2 -> 4 polls, rsp_valid with rsp_err=1, rsp_ct=0, no CT reads.
REQ-032 HRESP=1 on PT1 write -> no further transfers, rsp_valid with rsp_err=1 next DONE cycle.
REQ-033 HRESETn low during poll phase -> HTRANS=0 immediately, no rsp_valid, new command after release runs full sequence.

Source files
------------

// File: rtl/aes_ahb_host.sv
// AHB-Lite manager that sequences one AES-128 encryption on a memory-mapped
// AES core: loads key and plaintext, starts the core, polls status, reads back
// the ciphertext and reports the result on a one-cycle completion pulse.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready=1
// ADDR  | address phase of the current step (NONSEQ), held until HREADY
// DATA  | data phase of the current step, held until HREADY
// DONE  | single cycle, rsp_valid=1, then back to IDLE
//
// Step index: 0-3 KEY0..3, 4-7 PT0..3, 8 CTRL0, 9 STAT0 poll, 10-13 CT0..3.
module aes_ahb_host #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          POLL_LIMIT = 1024
) (
   input  logic         HCLK,
   input  logic         HRESETn,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [127:0] cmd_key,
   input  logic [127:0] cmd_pt,
   output logic         rsp_valid,
   output logic         rsp_err,
   output logic [127:0] rsp_ct,
   output logic [31:0]  HADDR,
   output logic [1:0]   HTRANS,
   output logic         HWRITE,
   output logic [2:0]   HSIZE,
   output logic [2:0]   HBURST,
   output logic [31:0]  HWDATA,
   input  logic [31:0]  HRDATA,
   input  logic         HREADY,
   input  logic         HRESP
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [3:0]  STEP_STAT = 4'd9;
   localparam logic [15:0] POLL_LIM  = 16'(POLL_LIMIT);

   logic [1:0]   state;
   logic [3:0]   step;
   logic [15:0]  poll_cnt;
   logic         seen_busy;
   logic [127:0] key_q;
   logic [127:0] pt_q;
   logic [95:0]  ct_q;

   logic [31:0]  step_addr;
   logic [31:0]  step_wdata;
   logic         step_wr;
   logic         step_ct;
   logic [1:0]   ct_idx;
   logic         in_xfer;
   logic         poll_done;

   // Decode the current step into address, direction, write data and CT slot.
   always_comb begin
      step_addr  = '0;
      step_wdata = '0;
      step_wr    = 1'b0;
      step_ct    = 1'b0;
      ct_idx     = 2'd0;
      case (step)
         4'd0, 4'd1, 4'd2, 4'd3: begin
            step_addr  = BASE_ADDR + 32'h10 + {28'd0, step[1:0], 2'b00};
            step_wdata = key_q[{step[1:0], 5'd0} +: 32];
            step_wr    = 1'b1;
         end
         4'd4, 4'd5, 4'd6, 4'd7: begin
            step_addr  = BASE_ADDR + 32'h20 + {28'd0, step[1:0], 2'b00};
            step_wdata = pt_q[{step[1:0], 5'd0} +: 32];
            step_wr    = 1'b1;
         end
         4'd8: begin
            step_addr  = BASE_ADDR;
            step_wdata = 32'h1;
            step_wr    = 1'b1;
         end
         4'd9: begin
            step_addr = BASE_ADDR + 32'h08;
         end
         4'd10: begin
            step_addr = BASE_ADDR + 32'h30;
            step_ct   = 1'b1;
            ct_idx    = 2'd0;
         end
         4'd11: begin
            step_addr = BASE_ADDR + 32'h34;
            step_ct   = 1'b1;
            ct_idx    = 2'd1;
         end
         4'd12: begin
            step_addr = BASE_ADDR + 32'h38;
            step_ct   = 1'b1;
            ct_idx    = 2'd2;
         end
         4'd13: begin
            step_addr = BASE_ADDR + 32'h3C;
            step_ct   = 1'b1;
            ct_idx    = 2'd3;
         end
         default: begin
            step_addr = '0;
         end
      endcase
   end

   // Polling ends on done, or on busy dropping after it was seen set earlier.
   assign poll_done = HRDATA[0] || (seen_busy && !HRDATA[1]);

   // Bus outputs follow the FSM directly so reset silences them immediately.
   assign in_xfer   = (state == S_ADDR) || (state == S_DATA);
   assign HTRANS    = (state == S_ADDR) ? 2'b10 : 2'b00;
   assign HADDR     = in_xfer ? step_addr : 32'h0;
   assign HWRITE    = in_xfer && step_wr;
   assign HWDATA    = ((state == S_DATA) && step_wr) ? step_wdata : 32'h0;
   assign HSIZE     = 3'b010;
   assign HBURST    = 3'b000;
   assign cmd_ready = (state == S_IDLE);
   assign rsp_valid = (state == S_DONE);

   // Sequencer: accept, walk the steps, poll, collect ciphertext, report.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= S_IDLE;
         step      <= '0;
         poll_cnt  <= '0;
         seen_busy <= 1'b0;
         key_q     <= '0;
         pt_q      <= '0;
         ct_q      <= '0;
         rsp_err   <= 1'b0;
         rsp_ct    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  key_q     <= cmd_key;
                  pt_q      <= cmd_pt;
                  step      <= '0;
                  poll_cnt  <= '0;
                  seen_busy <= 1'b0;
                  ct_q      <= '0;
                  rsp_err   <= 1'b0;
                  rsp_ct    <= '0;
                  state     <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (HREADY) state <= S_DATA;
            end
            S_DATA: begin
               if (HRESP) begin
                  // Error responses are terminal; ciphertext is never partial.
                  rsp_err <= 1'b1;
                  rsp_ct  <= '0;
                  state   <= S_DONE;
               end else if (HREADY) begin
                  if (step == STEP_STAT) begin
                     poll_cnt <= poll_cnt + 16'd1;
                     if (HRDATA[1]) seen_busy <= 1'b1;
                     if (poll_done) begin
                        step  <= step + 4'd1;
                        state <= S_ADDR;
                     end else if (poll_cnt + 16'd1 >= POLL_LIM) begin
                        rsp_err <= 1'b1;
                        rsp_ct  <= '0;
                        state   <= S_DONE;
                     end else begin
                        state <= S_ADDR;
                     end
                  end else if (step_ct) begin
                     case (ct_idx)
                        2'd0: ct_q[31:0]  <= HRDATA;
                        2'd1: ct_q[63:32] <= HRDATA;
                        2'd2: ct_q[95:64] <= HRDATA;
                        default: rsp_ct   <= {HRDATA, ct_q};
                     endcase
                     if (ct_idx == 2'd3) begin
                        state <= S_DONE;
                     end else begin
                        step  <= step + 4'd1;
                        state <= S_ADDR;
                     end
                  end else begin
                     step  <= step + 4'd1;
                     state <= S_ADDR;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_ahb_host.sv
// Scoreboard bench for aes_ahb_host: a reactive AHB subordinate model logs every
// completed transfer, a reference model predicts the transfer list and response
// of each command, and a monitor compares on every rsp_valid pulse.
module tb_aes_ahb_host;

   localparam logic [31:0] BASE_B = 32'h4000_1000;

   typedef struct packed {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] data;
   } xfer_t;

   typedef struct packed {
      logic         err;
      logic [127:0] ct;
      logic [31:0]  lat;
      logic [31:0]  nx;
   } rsp_t;

   logic HCLK = 1'b0;
   logic HRESETn = 1'b0;
   always #5 HCLK = ~HCLK;

   logic         cmd_valid = 1'b0;
   logic [127:0] cmd_key = '0;
   logic [127:0] cmd_pt = '0;
   logic         HREADY = 1'b1;
   logic         HRESP = 1'b0;
   logic [31:0]  HRDATA = '0;
   logic         sel = 1'b0;

   logic a_cmd_valid, b_cmd_valid;
   assign a_cmd_valid = cmd_valid && !sel;
   assign b_cmd_valid = cmd_valid && sel;

   logic         a_cmd_ready, b_cmd_ready, a_rsp_valid, b_rsp_valid, a_rsp_err, b_rsp_err;
   logic [127:0] a_rsp_ct, b_rsp_ct;
   logic [31:0]  a_haddr, b_haddr, a_hwdata, b_hwdata;
   logic [1:0]   a_htrans, b_htrans;
   logic         a_hwrite, b_hwrite;
   logic [2:0]   a_hsize, b_hsize, a_hburst, b_hburst;

   aes_ahb_host dut_a (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
      .cmd_key(cmd_key), .cmd_pt(cmd_pt),
      .rsp_valid(a_rsp_valid), .rsp_err(a_rsp_err), .rsp_ct(a_rsp_ct),
      .HADDR(a_haddr), .HTRANS(a_htrans), .HWRITE(a_hwrite), .HSIZE(a_hsize),
      .HBURST(a_hburst), .HWDATA(a_hwdata),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   aes_ahb_host #(.BASE_ADDR(BASE_B), .POLL_LIMIT(4)) dut_b (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
      .cmd_key(cmd_key), .cmd_pt(cmd_pt),
      .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err), .rsp_ct(b_rsp_ct),
      .HADDR(b_haddr), .HTRANS(b_htrans), .HWRITE(b_hwrite), .HSIZE(b_hsize),
      .HBURST(b_hburst), .HWDATA(b_hwdata),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   // The idle instance keeps HTRANS=IDLE, so the shared subordinate follows sel.
   logic         m_cmd_ready, m_rsp_valid, m_rsp_err, m_hwrite;
   logic [127:0] m_rsp_ct;
   logic [31:0]  m_haddr, m_hwdata;
   logic [1:0]   m_htrans;
   logic [2:0]   m_hsize, m_hburst;
   assign m_cmd_ready = sel ? b_cmd_ready : a_cmd_ready;
   assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
   assign m_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
   assign m_rsp_ct    = sel ? b_rsp_ct    : a_rsp_ct;
   assign m_haddr     = sel ? b_haddr     : a_haddr;
   assign m_hwdata    = sel ? b_hwdata    : a_hwdata;
   assign m_htrans    = sel ? b_htrans    : a_htrans;
   assign m_hwrite    = sel ? b_hwrite    : a_hwrite;
   assign m_hsize     = sel ? b_hsize     : a_hsize;
   assign m_hburst    = sel ? b_hburst    : a_hburst;

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int accept_cyc = 0;
   int done_cnt = 0;

   always @(posedge HCLK) cyc <= cyc + 1;

   // Subordinate / test configuration
   logic [31:0] base = '0;
   int          limit = 1024;
   logic [31:0] stat_q[$];
   logic [31:0] stat_dflt = 32'h1;
   logic [31:0] ct_w[4];
   logic        wait_en = 1'b0;
   logic [31:0] wait_addr = '0;
   int          wait_n = 0;
   logic        err_en = 1'b0;
   logic [31:0] err_addr = '0;

   xfer_t exp_x[$];
   xfer_t act_x[$];
   rsp_t  exp_r[$];
   rsp_t  last_exp;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   // Reference model: the command's bus transaction list and response.
   function automatic void model(input logic [127:0] key, input logic [127:0] pt);
      xfer_t       xs[$];
      logic [31:0] stats[$];
      logic [31:0] s;
      logic        err = 1'b0;
      logic        busy = 1'b0;
      logic        fin = 1'b0;
      int          polls = 0;
      int          lat;
      rsp_t        r;
      stats = stat_q;
      for (int i = 0; i < 4; i++) xs.push_back('{base + 32'h10 + 32'(4 * i), 1'b1, key[32 * i +: 32]});
      for (int i = 0; i < 4; i++) xs.push_back('{base + 32'h20 + 32'(4 * i), 1'b1, pt[32 * i +: 32]});
      xs.push_back('{base, 1'b1, 32'h1});
      while (!fin) begin
         s = (stats.size() > 0) ? stats.pop_front() : stat_dflt;
         polls++;
         xs.push_back('{base + 32'h8, 1'b0, s});
         if (s[0] || (busy && !s[1])) fin = 1'b1;
         else if (polls >= limit) begin
            fin = 1'b1;
            err = 1'b1;
         end
         if (s[1]) busy = 1'b1;
      end
      if (!err) for (int i = 0; i < 4; i++) xs.push_back('{base + 32'h30 + 32'(4 * i), 1'b0, ct_w[i]});
      if (err_en) begin
         for (int i = 0; i < xs.size(); i++) begin
            if (xs[i].addr == err_addr) begin
               xs = xs[0:i];
               err = 1'b1;
               break;
            end
         end
      end
      lat = 2 * xs.size() + 1;
      if (wait_en) begin
         for (int i = 0; i < xs.size(); i++) begin
            if (xs[i].addr == wait_addr) begin
               lat += wait_n;
               break;
            end
         end
      end
      r.err = err;
      r.ct  = err ? 128'h0 : {ct_w[3], ct_w[2], ct_w[1], ct_w[0]};
      r.lat = 32'(lat);
      r.nx  = 32'(xs.size());
      foreach (xs[i]) exp_x.push_back(xs[i]);
      exp_r.push_back(r);
      last_exp = r;
   endfunction

   // Subordinate state, sampled DUT outputs of the previous cycle
   logic        dp_act = 1'b0;
   logic [31:0] dp_addr = '0;
   logic        dp_wr = 1'b0;
   logic        dp_err = 1'b0;
   logic [31:0] dp_rdata = '0;
   int          wait_left = 0;
   logic [1:0]  p_htrans = '0;
   logic [31:0] p_haddr = '0;
   logic [31:0] p_hwdata = '0;
   logic        p_hwrite = 1'b0;

   // Subordinate response, transfer logging and response scoreboard.
   always @(negedge HCLK) begin
      if (!HRESETn) begin
         dp_act   = 1'b0;
         p_htrans = 2'b00;
         HREADY   = 1'b1;
         HRESP    = 1'b0;
         HRDATA   = '0;
      end else begin
         if (dp_act) begin
            if (HREADY) begin
               act_x.push_back('{dp_addr, dp_wr, dp_wr ? p_hwdata : dp_rdata});
               dp_act = 1'b0;
            end else begin
               wait_left--;
               chk("wait_stable", {62'd0, m_htrans, m_haddr, m_hwdata}, {62'd0, p_htrans, p_haddr, p_hwdata});
            end
         end
         if (p_htrans == 2'b10 && HREADY) begin
            dp_act   = 1'b1;
            dp_addr  = p_haddr;
            dp_wr    = p_hwrite;
            dp_err   = err_en && (p_haddr == err_addr);
            wait_left = 0;
            if (wait_en && p_haddr == wait_addr) begin
               wait_left = wait_n;
               wait_en   = 1'b0;
            end
            dp_rdata = '0;
            if (!p_hwrite) begin
               if (p_haddr == base + 32'h8)
                  dp_rdata = (stat_q.size() > 0) ? stat_q.pop_front() : stat_dflt;
               for (int i = 0; i < 4; i++)
                  if (p_haddr == base + 32'h30 + 32'(4 * i)) dp_rdata = ct_w[i];
            end
         end
         p_htrans = m_htrans;
         p_haddr  = m_haddr;
         p_hwdata = m_hwdata;
         p_hwrite = m_hwrite;
         if (dp_act && wait_left > 0) begin
            HREADY = 1'b0; HRESP = 1'b0; HRDATA = '0;
         end else if (dp_act) begin
            HREADY = 1'b1; HRESP = dp_err; HRDATA = dp_rdata;
         end else begin
            HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
         end
         if (m_rsp_valid) begin
            if (exp_r.size() == 0) begin
               chk("unexpected_rsp_valid", 128'(1), 128'(0));
            end else begin
               rsp_t  r;
               xfer_t a, e;
               r = exp_r.pop_front();
               chk("rsp_err", 128'(m_rsp_err), 128'(r.err));
               chk("rsp_ct", m_rsp_ct, r.ct);
               chk("latency", 128'(cyc + 1 - accept_cyc), 128'(r.lat));
               chk("xfer_count", 128'(act_x.size()), 128'(r.nx));
               for (int i = 0; i < int'(r.nx); i++) begin
                  e = (exp_x.size() > 0) ? exp_x.pop_front() : '0;
                  a = (act_x.size() > 0) ? act_x.pop_front() : '0;
                  chk($sformatf("xfer%0d", i), 128'(a), 128'(e));
               end
               act_x.delete();
            end
            done_cnt++;
         end
      end
   end

   task automatic select(input logic s);
      sel   = s;
      base  = s ? BASE_B : 32'h0;
      limit = s ? 4 : 1024;
   endtask

   task automatic clear_cfg();
      stat_q.delete();
      stat_dflt = 32'h1;
      wait_en   = 1'b0;
      err_en    = 1'b0;
      for (int i = 0; i < 4; i++) ct_w[i] = $urandom();
   endtask

   function automatic logic [31:0] pick_addr();
      logic [31:0] off;
      int k;
      k = $urandom_range(0, 13);
      if (k < 4) off = 32'h10 + 32'(4 * k);
      else if (k < 8) off = 32'h20 + 32'(4 * (k - 4));
      else if (k == 8) off = 32'h0;
      else if (k == 9) off = 32'h8;
      else off = 32'h30 + 32'(4 * (k - 10));
      return base + off;
   endfunction

   task automatic issue_op(input logic [127:0] key, input logic [127:0] pt);
      model(key, pt);
      chk("cmd_ready_before_issue", 128'(m_cmd_ready), 128'(1));
      cmd_key    = key;
      cmd_pt     = pt;
      cmd_valid  = 1'b1;
      accept_cyc = cyc + 1;
      @(posedge HCLK);
      #1;
      cmd_valid = 1'b0;
      cmd_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
      cmd_pt    = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge HCLK);
   endtask

   task automatic run_op(input logic [127:0] key, input logic [127:0] pt);
      int target;
      int g;
      target = done_cnt + 1;
      issue_op(key, pt);
      g = 0;
      while (done_cnt < target && g < 400) begin
         @(negedge HCLK);
         g++;
      end
      chk("rsp_within_budget", 128'(done_cnt >= target), 128'(1));
      if (done_cnt < target) begin
         exp_r.delete();
         exp_x.delete();
         act_x.delete();
      end
      repeat (3) @(negedge HCLK);
      chk("hold_rsp_err", 128'(m_rsp_err), 128'(last_exp.err));
      chk("hold_rsp_ct", m_rsp_ct, last_exp.ct);
      chk("hsize_hburst", 128'({m_hsize, m_hburst}), 128'(6'b010_000));
   endtask

   initial begin
      int g;
      int saved;
      int npre, nbusy;
      select(1'b0);
      clear_cfg();
      repeat (3) @(negedge HCLK);
      HRESETn = 1'b1;
      @(negedge HCLK);
      chk("reset_htrans", 128'(m_htrans), 128'(0));
      chk("reset_haddr", 128'(m_haddr), 128'(0));
      chk("reset_hwrite", 128'(m_hwrite), 128'(0));
      chk("reset_hwdata", 128'(m_hwdata), 128'(0));
      chk("reset_rsp_valid", 128'(m_rsp_valid), 128'(0));
      chk("reset_rsp_err", 128'(m_rsp_err), 128'(0));
      chk("reset_rsp_ct", m_rsp_ct, 128'(0));
      chk("reset_cmd_ready", 128'(m_cmd_ready), 128'(1));
      chk("reset_b_ready", 128'({b_cmd_ready, b_rsp_valid, b_htrans}), 128'(4'b1000));

      // Zero-wait, one poll: 14 transfers, rsp_valid at 29
      clear_cfg();
      stat_q.push_back(32'h1);
      run_op(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff);

      // Three wait states in the KEY2 data phase
      clear_cfg();
      wait_en = 1'b1; wait_addr = base + 32'h18; wait_n = 3;
      run_op({4{$urandom()}}, {4{$urandom()}});

      // Busy four times then idle: five polls
      clear_cfg();
      for (int i = 0; i < 4; i++) stat_q.push_back(32'h2);
      stat_q.push_back(32'h0);
      run_op({4{$urandom()}}, {4{$urandom()}});

      // Error response on the PT1 write
      clear_cfg();
      err_en = 1'b1; err_addr = base + 32'h24;
      run_op({4{$urandom()}}, {4{$urandom()}});

      // Poll limit on the POLL_LIMIT=4 instance
      select(1'b1);
      clear_cfg();
      stat_dflt = 32'h2;
      run_op({4{$urandom()}}, {4{$urandom()}});
      clear_cfg();
      run_op({4{$urandom()}}, {4{$urandom()}});

      // Reset during the poll phase abandons the operation
      select(1'b0);
      clear_cfg();
      stat_dflt = 32'h2;
      saved = done_cnt;
      issue_op({4{$urandom()}}, {4{$urandom()}});
      g = 0;
      while (!(m_htrans == 2'b10 && act_x.size() >= 10) && g < 200) begin
         @(negedge HCLK);
         g++;
      end
      chk("in_poll_before_reset", 128'(m_haddr), 128'(base + 32'h8));
      #2 HRESETn = 1'b0;
      #1;
      chk("htrans_on_reset", 128'(m_htrans), 128'(0));
      chk("rsp_valid_on_reset", 128'(m_rsp_valid), 128'(0));
      @(negedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      exp_r.delete();
      exp_x.delete();
      act_x.delete();
      repeat (4) @(negedge HCLK);
      chk("no_rsp_after_abort", 128'(done_cnt), 128'(saved));
      clear_cfg();
      run_op({4{$urandom()}}, {4{$urandom()}});

      // Randomised commands across both instances
      for (int t = 0; t < 12; t++) begin
         select(t % 3 == 2);
         clear_cfg();
         npre  = $urandom_range(0, 2);
         nbusy = $urandom_range(0, 3);
         for (int i = 0; i < npre; i++) stat_q.push_back($urandom() & ~32'h3);
         for (int i = 0; i < nbusy; i++) stat_q.push_back(($urandom() & ~32'h3) | 32'h2);
         if (nbusy > 0 && $urandom_range(0, 1) == 1) stat_q.push_back($urandom() & ~32'h3);
         else stat_q.push_back(($urandom() & ~32'h1) | 32'h1);
         wait_en   = ($urandom_range(0, 2) == 0);
         wait_addr = pick_addr();
         wait_n    = $urandom_range(1, 3);
         err_en    = ($urandom_range(0, 4) == 0);
         err_addr  = pick_addr();
         run_op({$urandom(), $urandom(), $urandom(), $urandom()},
                {$urandom(), $urandom(), $urandom(), $urandom()});
      end

      chk("scoreboard_drained", 128'(exp_r.size() + exp_x.size()), 128'(0));
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
